// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and operand-forwarding control for a five-stage pipeline.
// Shadows destination info for E/M/W and compares it against the operands of the D-stage instruction.
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [1:0]       tuse_rs,
  input  logic [1:0]       tuse_rt,
  input  logic [4:0]       wreg_d,
  input  logic [1:0]       tnew_d,
  input  logic [1:0]       wsrc_d,
  input  logic             md_busy,
  input  logic             md_use_d,
  output logic [2:0]       fwd_rs_d,
  output logic [2:0]       fwd_rt_d,
  output logic [2:0]       fwd_rs_e,
  output logic [2:0]       fwd_rt_e,
  output logic [2:0]       fwd_rt_m,
  output logic             stall,
  output logic             flush_e,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [1:0] SRC_ALU   = 2'd0;
  localparam logic [1:0] SRC_LINK  = 2'd1;
  localparam logic [2:0] SEL_RF    = 3'd0;
  localparam logic [2:0] SEL_E_PC8 = 3'd1;
  localparam logic [2:0] SEL_M_ALU = 3'd2;
  localparam logic [2:0] SEL_M_PC8 = 3'd3;
  localparam logic [2:0] SEL_W     = 3'd4;

  logic [4:0]       r_e_rs, r_e_rt, r_e_wreg;
  logic [1:0]       r_e_tnew, r_e_wsrc;
  logic [4:0]       r_m_rt, r_m_wreg;
  logic [1:0]       r_m_tnew, r_m_wsrc;
  logic [4:0]       r_w_wreg;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  function automatic logic hazard(input logic [4:0] src, input logic [1:0] tuse,
                                  input logic [4:0] wreg, input logic [1:0] tnew);
    return (src != 5'd0) && (src == wreg) && (tuse < tnew);
  endfunction

  // A matching M entry that is not ready yet shadows W (the stall covers that case).
  function automatic logic [2:0] sel_mw(input logic [4:0] src, input logic [4:0] m_wreg,
                                        input logic [1:0] m_tnew, input logic [1:0] m_wsrc,
                                        input logic [4:0] wb_wreg);
    logic [2:0] sel;
    if (src == 5'd0) sel = SEL_RF;
    else if (src == m_wreg) begin
      if (m_tnew != 2'd0)           sel = SEL_RF;
      else if (m_wsrc == SRC_ALU)   sel = SEL_M_ALU;
      else if (m_wsrc == SRC_LINK)  sel = SEL_M_PC8;
      else                          sel = SEL_RF;
    end
    else if (src == wb_wreg) sel = SEL_W;
    else sel = SEL_RF;
    return sel;
  endfunction

  function automatic logic [2:0] sel_d(input logic [4:0] src, input logic [4:0] e_wreg,
                                       input logic [1:0] e_tnew, input logic [1:0] e_wsrc,
                                       input logic [4:0] m_wreg, input logic [1:0] m_tnew,
                                       input logic [1:0] m_wsrc, input logic [4:0] wb_wreg);
    logic [2:0] sel;
    if ((src != 5'd0) && (src == e_wreg))
      sel = ((e_tnew == 2'd0) && (e_wsrc == SRC_LINK)) ? SEL_E_PC8 : SEL_RF;
    else
      sel = sel_mw(src, m_wreg, m_tnew, m_wsrc, wb_wreg);
    return sel;
  endfunction

  assign w_stall = hazard(rs_d, tuse_rs, r_e_wreg, r_e_tnew) |
                   hazard(rt_d, tuse_rt, r_e_wreg, r_e_tnew) |
                   hazard(rs_d, tuse_rs, r_m_wreg, r_m_tnew) |
                   hazard(rt_d, tuse_rt, r_m_wreg, r_m_tnew) |
                   (md_busy & md_use_d);

  assign stall     = w_stall;
  assign flush_e   = w_stall;
  assign stall_cnt = r_stall_cnt;

  assign fwd_rs_d = sel_d(rs_d, r_e_wreg, r_e_tnew, r_e_wsrc, r_m_wreg, r_m_tnew, r_m_wsrc, r_w_wreg);
  assign fwd_rt_d = sel_d(rt_d, r_e_wreg, r_e_tnew, r_e_wsrc, r_m_wreg, r_m_tnew, r_m_wsrc, r_w_wreg);
  assign fwd_rs_e = sel_mw(r_e_rs, r_m_wreg, r_m_tnew, r_m_wsrc, r_w_wreg);
  assign fwd_rt_e = sel_mw(r_e_rt, r_m_wreg, r_m_tnew, r_m_wsrc, r_w_wreg);
  assign fwd_rt_m = ((r_m_rt != 5'd0) && (r_m_rt == r_w_wreg)) ? SEL_W : SEL_RF;

  // Shadow pipeline advance (bubble into E on stall) and saturating stall counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e_rs      <= 5'd0;
      r_e_rt      <= 5'd0;
      r_e_wreg    <= 5'd0;
      r_e_tnew    <= 2'd0;
      r_e_wsrc    <= 2'd0;
      r_m_rt      <= 5'd0;
      r_m_wreg    <= 5'd0;
      r_m_tnew    <= 2'd0;
      r_m_wsrc    <= 2'd0;
      r_w_wreg    <= 5'd0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall) begin
        r_e_rs   <= 5'd0;
        r_e_rt   <= 5'd0;
        r_e_wreg <= 5'd0;
        r_e_tnew <= 2'd0;
        r_e_wsrc <= 2'd0;
      end else begin
        r_e_rs   <= rs_d;
        r_e_rt   <= rt_d;
        r_e_wreg <= wreg_d;
        r_e_tnew <= tnew_d;
        r_e_wsrc <= wsrc_d;
      end
      r_m_rt   <= r_e_rt;
      r_m_wreg <= r_e_wreg;
      r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : (r_e_tnew - 2'd1);
      r_m_wsrc <= r_e_wsrc;
      r_w_wreg <= r_m_wreg;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      else
        r_stall_cnt <= r_stall_cnt;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations are queued as D inputs are driven and drained mid-cycle.
module tb_hazard_ctrl;
  localparam int CW = 3;
  localparam int S_STALL = 0, S_FLUSH = 1, S_RSD = 2, S_RTD = 3, S_RSE = 4, S_RTE = 5, S_RTM = 6, S_CNT = 7;

  typedef struct {
    logic [4:0] rs, rt;
    logic [1:0] tus, tut;
    logic [4:0] wr;
    logic [1:0] tn, ws;
    logic       mb, mu;
  } d_t;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] rs_d, rt_d, wreg_d;
  logic [1:0] tuse_rs, tuse_rt, tnew_d, wsrc_d;
  logic md_busy, md_use_d;
  logic [2:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m;
  logic stall, flush_e;
  logic [CW-1:0] stall_cnt;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_cnt = 0;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .wreg_d(wreg_d), .tnew_d(tnew_d),
    .wsrc_d(wsrc_d), .md_busy(md_busy), .md_use_d(md_use_d),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
    .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .stall(stall),
    .flush_e(flush_e), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic d_t mk(input logic [4:0] rs, input logic [4:0] rt,
                            input logic [1:0] tus, input logic [1:0] tut,
                            input logic [4:0] wr, input logic [1:0] tn,
                            input logic [1:0] ws, input logic mb, input logic mu);
    d_t d;
    d.rs = rs; d.rt = rt; d.tus = tus; d.tut = tut;
    d.wr = wr; d.tn = tn; d.ws = ws; d.mb = mb; d.mu = mu;
    return d;
  endfunction

  function automatic d_t idle();
    return mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0);
  endfunction

  task automatic drive(input d_t d);
    rs_d = d.rs; rt_d = d.rt; tuse_rs = d.tus; tuse_rt = d.tut;
    wreg_d = d.wr; tnew_d = d.tn; wsrc_d = d.ws; md_busy = d.mb; md_use_d = d.mu;
  endtask

  function automatic void push(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.sig = sig; e.val = val;
    sb.push_back(e);
  endfunction

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      S_STALL: observe = {31'd0, stall};
      S_FLUSH: observe = {31'd0, flush_e};
      S_RSD:   observe = {29'd0, fwd_rs_d};
      S_RTD:   observe = {29'd0, fwd_rt_d};
      S_RSE:   observe = {29'd0, fwd_rs_e};
      S_RTE:   observe = {29'd0, fwd_rt_e};
      S_RTM:   observe = {29'd0, fwd_rt_m};
      S_CNT:   observe = 32'(stall_cnt);
      default: observe = 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      case (c)
        0: begin
          drive(idle());
          push("rst_stall", S_STALL, 32'd0); push("rst_flush", S_FLUSH, 32'd0);
          push("rst_rsd", S_RSD, 32'd0); push("rst_rtd", S_RTD, 32'd0);
          push("rst_rse", S_RSE, 32'd0); push("rst_rte", S_RTE, 32'd0);
          push("rst_rtm", S_RTM, 32'd0); push("rst_cnt", S_CNT, 32'd0);
        end
        1: begin
          drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b1, 1'b1));
          push("rst_md_stall", S_STALL, 32'd1); push("rst_md_flush", S_FLUSH, 32'd1);
        end
        default: drive(idle());
      endcase
      #4;
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (observe(e.sig) !== e.val) begin
          n_fail++; $display("FAIL %s: got %0d expected %0d", e.tag, observe(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
    drive(idle());
    reset_n = 1'b1;
  endtask

  task automatic test_alu_use();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      case (c)
        0: begin drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd1, 2'd0, 1'b0, 1'b0)); push("alu_prod_stall", S_STALL, 32'd0); end
        1: begin drive(mk(5'd8, 5'd0, 2'd1, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0)); push("alu_use_stall", S_STALL, 32'd0); end
        2: begin drive(idle()); push("alu_fwd_rs_e", S_RSE, 32'd2); end
        default: drive(idle());
      endcase
      #4;
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (observe(e.sig) !== e.val) begin
          n_fail++; $display("FAIL %s: got %0d expected %0d", e.tag, observe(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2, 2'd2, 1'b0, 1'b0)); push("ld_prod_stall", S_STALL, 32'd0); end
        1, 2: begin
          drive(mk(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("ld_use_stall", S_STALL, 32'd1); push("ld_use_flush", S_FLUSH, 32'd1);
          exp_cnt++;
        end
        3: begin
          drive(mk(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("ld_release_stall", S_STALL, 32'd0); push("ld_fwd_rs_d", S_RSD, 32'd4);
          push("ld_cnt", S_CNT, 32'(exp_cnt));
        end
        default: drive(idle());
      endcase
      #4;
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (observe(e.sig) !== e.val) begin
          n_fail++; $display("FAIL %s: got %0d expected %0d", e.tag, observe(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_link();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd31, 2'd0, 2'd1, 1'b0, 1'b0)); push("jal_stall", S_STALL, 32'd0); end
        1: begin
          drive(mk(5'd0, 5'd31, 2'd3, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("jal_fwd_rt_d_e", S_RTD, 32'd1); push("jal_e_stall", S_STALL, 32'd0);
        end
        2: begin
          drive(mk(5'd0, 5'd31, 2'd3, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("jal_fwd_rt_d_m", S_RTD, 32'd3); push("jal_fwd_rt_e_m", S_RTE, 32'd3);
          push("jal_m_stall", S_STALL, 32'd0);
        end
        3: begin
          drive(idle());
          push("jal_fwd_rt_m_w", S_RTM, 32'd4); push("jal_fwd_rt_e_w", S_RTE, 32'd4);
        end
        default: drive(idle());
      endcase
      #4;
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (observe(e.sig) !== e.val) begin
          n_fail++; $display("FAIL %s: got %0d expected %0d", e.tag, observe(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reg0_and_tuse();
    exp_t e;
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 2'd2, 1'b0, 1'b0));
        1: begin
          drive(mk(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("r0_stall", S_STALL, 32'd0); push("r0_fwd_rs_d", S_RSD, 32'd0);
        end
        2: drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd10, 2'd2, 2'd2, 1'b0, 1'b0));
        3: begin drive(mk(5'd0, 5'd10, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0)); push("tuse3_stall", S_STALL, 32'd0); end
        4: begin
          drive(mk(5'd10, 5'd10, 2'd0, 2'd1, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("m_hazard_stall", S_STALL, 32'd1); exp_cnt++;
        end
        5: begin
          drive(mk(5'd10, 5'd10, 2'd0, 2'd1, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("m_release_stall", S_STALL, 32'd0); push("w_fwd_rs_d", S_RSD, 32'd4);
          push("w_fwd_rt_d", S_RTD, 32'd4); push("tuse_cnt", S_CNT, 32'(exp_cnt));
        end
        default: drive(idle());
      endcase
      #4;
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (observe(e.sig) !== e.val) begin
          n_fail++; $display("FAIL %s: got %0d expected %0d", e.tag, observe(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority_md();
    exp_t e;
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd1, 2'd0, 1'b0, 1'b0));
        1: drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd5, 2'd0, 2'd1, 1'b0, 1'b0));
        2: begin
          drive(mk(5'd5, 5'd5, 2'd0, 2'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("prio_fwd_rs_d", S_RSD, 32'd1); push("prio_fwd_rt_d", S_RTD, 32'd1);
          push("prio_stall", S_STALL, 32'd0);
        end
        3, 4, 5: begin
          drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b1, 1'b1));
          push("md_busy_stall", S_STALL, 32'd1); exp_cnt++;
        end
        6: begin
          drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b1));
          push("md_free_stall", S_STALL, 32'd0); push("md_cnt", S_CNT, 32'(exp_cnt));
        end
        default: drive(idle());
      endcase
      #4;
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (observe(e.sig) !== e.val) begin
          n_fail++; $display("FAIL %s: got %0d expected %0d", e.tag, observe(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      push("sat_cnt", S_CNT, 32'(exp_cnt));
      if (c < 4) begin
        drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 2'd0, 1'b1, 1'b1));
        if (exp_cnt < (2 ** CW) - 1) exp_cnt++;
      end else begin
        drive(idle());
      end
      #4;
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (observe(e.sig) !== e.val) begin
          n_fail++; $display("FAIL %s: got %0d expected %0d", e.tag, observe(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: drive(mk(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2, 2'd2, 1'b0, 1'b0));
        1: begin
          drive(mk(5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0));
          push("pre_rst_stall", S_STALL, 32'd1); push("pre_rst_cnt", S_CNT, 32'(exp_cnt));
        end
        2: begin
          reset_n = 1'b0; exp_cnt = 0;
          push("mid_rst_stall", S_STALL, 32'd0); push("mid_rst_flush", S_FLUSH, 32'd0);
          push("mid_rst_cnt", S_CNT, 32'd0); push("mid_rst_rsd", S_RSD, 32'd0);
        end
        3, 4: begin
          reset_n = 1'b1;
          push("post_rst_stall", S_STALL, 32'd0); push("post_rst_rsd", S_RSD, 32'd0);
          push("post_rst_cnt", S_CNT, 32'd0);
        end
        default: drive(idle());
      endcase
      #4;
      while (sb.size() != 0) begin
        e = sb.pop_front(); n_checks++;
        if (observe(e.sig) !== e.val) begin
          n_fail++; $display("FAIL %s: got %0d expected %0d", e.tag, observe(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(idle());
    test_reset();
    test_alu_use();
    test_load_use();
    test_link();
    test_reg0_and_tuse();
    test_priority_md();
    test_saturation();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset; clears all state immediately on assertion.
REQ-004 rs_d, rt_d  in  5 each  D-stage source register numbers.
REQ-005 tuse_rs, tuse_rt  in  2 each  D-stage cycles until operand is needed (0 = in D, 1 = in E, 2 = in M, 3 = not used).
REQ-006 wreg_d  in  5  D-stage destination register; 0 means no write.
REQ-007 tnew_d  in  2  cycles after entering E until result exists (0 = link PC+8, 1 = ALU, 2 = load).
REQ-008 wsrc_d  in  2  result source: 0 = ALU, 1 = link, 2 = memory.
REQ-009 md_busy, md_use_d  in  1 each  mult/div unit busy; D instruction touches HI/LO or mult/div.
REQ-010 fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m  out  3 each  forward-mux selects for D, E and M operand muxes.
REQ-011 stall  out  1  freeze PC and F/D register.
REQ-012 flush_e  out  1  load bubble into D/E register.
REQ-013 stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-014 Select encoding SHALL be: 0 = register-file value, 1 = E-stage PC4+4, 2 = M-stage ALU output, 3 = M-stage PC4+4, 4 = W-stage write data; codes 5-7 SHALL never be driven.
REQ-015 Shadow pipeline SHALL hold per-stage {rs, rt, wreg, tnew, wsrc} for E, plus {rt, wreg, tnew, wsrc} for M and {wreg} for W.
REQ-016 Each non-stalled cycle, D fields SHALL enter E, E SHALL shift to M, and M SHALL shift to W.
REQ-017 On a stalled cycle, E SHALL load all-zero (bubble), and M and W SHALL still shift.
REQ-018 When E shifts into M, tnew SHALL decrement, saturating at 0; tnew in W is always 0.
REQ-019 Stall SHALL assert combinationally when any of the following holds:
- an operand with register != 0 matches E.wreg and its tuse < E.tnew;
- an operand with register != 0 matches M.wreg and its tuse < M.tnew;
- md_use_d and md_busy are both 1.
REQ-020 flush_e SHALL equal stall.
REQ-021 D-stage operand forwarding SHALL use priority E > M > W, considering register 0 never:
- E match with E.tnew = 0 and wsrc = link -> 1;
- else M match with M.tnew = 0 -> 2 for ALU or 3 for link;
- else W match -> 4;
- else 0.
REQ-022 E-stage operands SHALL use M, then W, with the same rules; the E source is excluded.
REQ-023 fwd_rt_m SHALL be 4 on a W match with rt != 0, else 0.
REQ-024 A matching stage whose result is not ready SHALL shadow older stages; stall then covers it, and the select value in that cycle is don't-care but within 0-4.
REQ-025 stall_cnt SHALL increment each cycle stall = 1 and hold at 2^CNT_W-1.
REQ-026 All outputs SHALL be functions of current state and current D inputs only; the block has no latency beyond the shadow registers.

Reset
REQ-027 While reset_n = 0, all shadow fields and stall_cnt SHALL be 0, so all fwd_* = 0 and stall = 0 absent a D-side mult/div conflict.
REQ-028 Reset asserted mid-stall SHALL clear state in the same cycle; on release, the stall SHALL deassert unless it is re-triggered from D inputs.

Verification
REQ-029 ALU then dependent use: cycle n D wreg_d = 8, tnew = 1, wsrc = 0; cycle n+1 rs_d = 8, tuse = 1 -> stall = 0 at n+1, fwd_rs_e = 2 at n+2.
REQ-030 Load-use: D wreg_d = 9, tnew = 2, wsrc = 2; next D rs_d = 9, tuse = 0 -> stall = 1 for 2 cycles, then fwd_rs_d = 4, stall_cnt = 2.
REQ-031 jal link: wreg_d = 31, tnew = 0, wsrc = 1; next D rt_d = 31, tuse = 0 -> fwd_rt_d = 1, no stall; one cycle later a D reader sees 3.
REQ-032 Register 0: wreg_d = 0, tnew = 2; next rs_d = 0, tuse = 0 -> stall = 0, fwd_rs_d = 0.
REQ-033 Priority: E and M both write reg 5, both ready in the E stage's view -> fwd_rs_d = 1; md_busy = 1 with md_use_d = 1 -> stall = 1 until md_busy drops.
REQ-034 Assert reset_n = 0 during a load-use stall -> stall = 0 and stall_cnt = 0 immediately; shadow stages are empty after release.
